// File: rtl/gates_chk_pkg.sv
// Shared definitions for the gates vector checker.
//   state_e     : checker FSM state encoding
//   NUM_VEC     : number of stimulus vectors in the run
//   VEC_LIST    : stimulus vectors as {a,b,c}; entry 0 is the rightmost field
//   expected_t  : golden {t0,t1,t2} for a given {a,b,c}
package gates_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    localparam int NUM_VEC = 6;

    // index:                            5       4       3       2       1       0
    localparam logic [NUM_VEC-1:0][2:0] VEC_LIST = {3'b000, 3'b001, 3'b110, 3'b100, 3'b010, 3'b000};

    // t0 = a AND b, t1 = a OR b, t2 = NOT c
    function automatic logic [2:0] expected_t(input logic [2:0] abc);
        return {abc[2] & abc[1], abc[2] | abc[1], ~abc[0]};
    endfunction

endpackage

// File: rtl/gates_vec_rom.sv
// Combinational vector lookup for the gates checker.
//   idx   : vector index (0..NUM_VEC-1); out-of-range indices read as zero
//   vec   : stimulus {a,b,c} for this index
//   exp_t : golden response {t0,t1,t2} for this index
module gates_vec_rom
    import gates_chk_pkg::*;
(
    input  logic [2:0] idx,
    output logic [2:0] vec,
    output logic [2:0] exp_t
);

    always_comb begin
        vec = 3'b000;
        if (idx < 3'(NUM_VEC)) begin
            vec = VEC_LIST[idx];
        end
        exp_t = expected_t(vec);
    end

endmodule

// File: rtl/gates_vector_checker.sv
// Self-checking stimulus/response engine for the basic gates block.
// Steps through the package vector list, holds each vector HOLD_CYCLES
// cycles (legal 1..255), samples t0/t1/t2 on the last cycle of the hold
// window and accumulates mismatch status.
//
// state  | meaning
// IDLE   | waiting for start, all outputs low
// DRIVE  | driving vector idx, counting the hold window
// FINISH | run complete, results held until the next start
//
// Ports:
//   clk, rst           : clock (rising edge) and async active-high reset
//   start              : single-cycle run request (ignored while busy)
//   drv_a/drv_b/drv_c  : stimulus to the gates block
//   t0/t1/t2           : gates block responses
//   busy, done, pass   : run status; pass is valid while done=1
//   err_count          : mismatching vectors, saturating at 15
//   fail_valid         : at least one mismatch this run
//   first_fail_idx     : index of the first mismatching vector
module gates_vector_checker
    import gates_chk_pkg::*;
#(
    parameter int HOLD_CYCLES = 20
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       drv_a,
    output logic       drv_b,
    output logic       drv_c,
    input  logic       t0,
    input  logic       t1,
    input  logic       t2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic       fail_valid,
    output logic [2:0] first_fail_idx
);

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_DRIVE  = ST_DRIVE;
    localparam logic [1:0] S_FINISH = ST_FINISH;

    localparam logic [7:0] CNT_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [2:0] IDX_LAST = 3'(NUM_VEC - 1);

    logic [1:0] state;
    logic [2:0] idx;
    logic [7:0] cnt;

    logic [2:0] rom_vec;
    logic [2:0] rom_exp;
    logic       sample_edge;
    logic       mismatch;

    gates_vec_rom u_rom (
        .idx   (idx),
        .vec   (rom_vec),
        .exp_t (rom_exp)
    );

    // Stimulus is a decode of registered state/idx, so the new vector
    // appears on the same edge that advances idx, and drops to zero
    // outside DRIVE (including immediately on reset).
    always_comb begin
        {drv_a, drv_b, drv_c} = 3'b000;
        if (state == S_DRIVE) begin
            {drv_a, drv_b, drv_c} = rom_vec;
        end
    end

    assign sample_edge = (state == S_DRIVE) && (cnt == CNT_LAST);
    assign mismatch    = ({t0, t1, t2} != rom_exp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            idx            <= 3'd0;
            cnt            <= 8'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 4'd0;
            fail_valid     <= 1'b0;
            first_fail_idx <= 3'd0;
        end else begin
            case (state)
                S_IDLE, S_FINISH: begin
                    if (start) begin
                        state          <= S_DRIVE;
                        idx            <= 3'd0;
                        cnt            <= 8'd0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_count      <= 4'd0;
                        fail_valid     <= 1'b0;
                        first_fail_idx <= 3'd0;
                    end
                end
                S_DRIVE: begin
                    if (!sample_edge) begin
                        cnt <= cnt + 8'd1;
                    end else begin
                        if (mismatch) begin
                            if (err_count != 4'hF) begin
                                err_count <= err_count + 4'd1;
                            end
                            if (!fail_valid) begin
                                fail_valid     <= 1'b1;
                                first_fail_idx <= idx;
                            end
                        end
                        if (idx == IDX_LAST) begin
                            state <= S_FINISH;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            // fail_valid has not yet absorbed this sample
                            pass  <= !(fail_valid || mismatch);
                        end else begin
                            idx <= idx + 3'd1;
                            cnt <= 8'd0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gates_vector_checker.sv
module tb_gates_vector_checker;

    typedef struct packed {
        logic [3:0] err;
        logic       fv;
        logic [2:0] ffi;
        logic       pass;
    } result_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start_h1 = 1'b0;

    logic       drv_a, drv_b, drv_c, t0, t1, t2;
    logic       busy, done, pass, fail_valid;
    logic [3:0] err_count;
    logic [2:0] first_fail_idx;

    logic       drv_a_h1, drv_b_h1, drv_c_h1, t0_h1, t1_h1, t2_h1;
    logic       busy_h1, done_h1, pass_h1, fail_valid_h1;
    logic [3:0] err_count_h1;
    logic [2:0] first_fail_idx_h1;

    int fault_mode = 0;   // 0 good, 1 t0 stuck at 0, 2 t2 = c
    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [2:0] tb_vec [6] = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b000};

    result_t    res_q[$];
    logic [2:0] drv_q[$];

    always #5 clk = ~clk;

    // gates block model, with optional planted faults
    assign t0 = (fault_mode == 1) ? 1'b0 : (drv_a & drv_b);
    assign t1 = drv_a | drv_b;
    assign t2 = (fault_mode == 2) ? drv_c : ~drv_c;

    assign t0_h1 = drv_a_h1 & drv_b_h1;
    assign t1_h1 = drv_a_h1 | drv_b_h1;
    assign t2_h1 = ~drv_c_h1;

    gates_vector_checker #(.HOLD_CYCLES(20)) dut (
        .clk(clk), .rst(rst), .start(start),
        .drv_a(drv_a), .drv_b(drv_b), .drv_c(drv_c),
        .t0(t0), .t1(t1), .t2(t2),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_valid(fail_valid),
        .first_fail_idx(first_fail_idx)
    );

    gates_vector_checker #(.HOLD_CYCLES(1)) dut_h1 (
        .clk(clk), .rst(rst), .start(start_h1),
        .drv_a(drv_a_h1), .drv_b(drv_b_h1), .drv_c(drv_c_h1),
        .t0(t0_h1), .t1(t1_h1), .t2(t2_h1),
        .busy(busy_h1), .done(done_h1), .pass(pass_h1),
        .err_count(err_count_h1), .fail_valid(fail_valid_h1),
        .first_fail_idx(first_fail_idx_h1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic result_t model_run(input int mode);
        result_t r;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            logic a, b, c, g0, g1, g2;
            {a, b, c} = tb_vec[i];
            g0 = (mode == 1) ? 1'b0 : (a & b);
            g1 = a | b;
            g2 = (mode == 2) ? c : ~c;
            if ({g0, g1, g2} != {a & b, a | b, ~c}) begin
                if (!r.fv) begin
                    r.fv  = 1'b1;
                    r.ffi = 3'(i);
                end
                if (r.err != 4'd15) r.err = r.err + 4'd1;
            end
        end
        r.pass = !r.fv;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full run on the HOLD_CYCLES=20 instance; glitch_at > 0 injects a
    // start pulse sampled at edge k+glitch_at.
    task automatic run(input int mode, input int glitch_at, input string tag);
        result_t r;
        int      cyc;
        bit      seen_done;
        bit      busy_ok;
        fault_mode = mode;
        res_q.delete();
        drv_q.delete();
        res_q.push_back(model_run(mode));
        for (int i = 0; i < 6; i++) drv_q.push_back(tb_vec[i]);

        @(negedge clk);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " busy_at_k"}, busy, 1);
        check({tag, " done_at_k"}, done, 0);

        cyc = 0;
        seen_done = 0;
        busy_ok = 1;
        while (!seen_done && cyc < 300) begin
            if ((cyc % 20) == 0 && cyc < 120 && drv_q.size() > 0)
                check($sformatf("%s drv_vec%0d", tag, cyc / 20), {drv_a, drv_b, drv_c}, drv_q.pop_front());
            start = (glitch_at > 0 && cyc == glitch_at - 1);
            tick();
            cyc++;
            if (done) seen_done = 1;
            else if (!busy) busy_ok = 0;
        end
        start = 1'b0;

        check({tag, " done_latency"}, cyc, 120);
        check({tag, " busy_held"}, busy_ok, 1);
        check({tag, " busy_after"}, busy, 0);
        check({tag, " drv_after"}, {drv_a, drv_b, drv_c}, 3'b000);
        if (res_q.size() > 0) begin
            r = res_q.pop_front();
            check({tag, " err_count"}, err_count, r.err);
            check({tag, " fail_valid"}, fail_valid, r.fv);
            check({tag, " first_fail_idx"}, first_fail_idx, r.ffi);
            check({tag, " pass"}, pass, r.pass);
            repeat (5) tick();
            check({tag, " done_hold"}, done, 1);
            check({tag, " result_hold"}, {err_count, fail_valid, first_fail_idx, pass}, r);
        end
    endtask

    initial begin
        // reset state
        repeat (3) tick();
        check("rst drv", {drv_a, drv_b, drv_c}, 3'b000);
        check("rst status", {busy, done, pass, fail_valid}, 4'b0000);
        check("rst err_count", err_count, 0);
        check("rst first_fail_idx", first_fail_idx, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) tick();

        // clean run with an ignored mid-run start at k+30
        run(0, 30, "clean_glitch");
        // t0 stuck at 0: only vector 3 mismatches
        run(1, 0, "t0_stuck");
        // t2 inverted: every vector mismatches
        run(2, 0, "t2_inv");
        // restart with good gates clears previous errors
        run(0, 0, "clean_after_err");

        // reset mid-run at k+50
        fault_mode = 0;
        @(negedge clk);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (49) tick();
        @(posedge clk);
        rst = 1'b1;
        #1;
        check("midrst drv", {drv_a, drv_b, drv_c}, 3'b000);
        check("midrst status", {busy, done, pass, fail_valid}, 4'b0000);
        check("midrst err_fidx", {err_count, first_fail_idx}, 7'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();
        check("midrst stays_idle", {busy, done}, 2'b00);
        run(0, 0, "after_rst");

        // HOLD_CYCLES=1 instance
        @(negedge clk);
        start_h1 = 1'b1;
        tick();
        start_h1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("h1 drv_edge%0d", i), {drv_a_h1, drv_b_h1, drv_c_h1}, tb_vec[i]);
            check($sformatf("h1 done_edge%0d", i), done_h1, 0);
            tick();
        end
        check("h1 done", done_h1, 1);
        check("h1 pass", pass_h1, 1);
        check("h1 err", {err_count_h1, fail_valid_h1}, 5'd0);
        check("h1 drv_after", {drv_a_h1, drv_b_h1, drv_c_h1}, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
